gbuf_write_arbiter: RTL and testbench
=====================================

Name: gbuf_write_arbiter

Overview:
- Shares the single graphic-buffer write port (buff_addr/buff_data/buff_wr) between up to NUM_REQ chart/graphic writers.
- Round-robin arbitration with per-burst grant lock, so a requester's line burst is never interleaved.
- A one-entry registered output stage with valid/ready backpressure from the buffer side.
- Sits between the chart-class generators and the frame/graphic buffer memory controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, buffer address width.
- DATA_W, 32, buffer data width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- ce  input  1  clock enable; gates new acceptances only.
- req_valid  input  NUM_REQ  per-requester write request.
- req_last  input  NUM_REQ  marks final beat of a burst (single writes: tie 1).
- req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed data, same packing.
- req_mask  input  NUM_REQ  1 = requester enabled for arbitration.
- req_ready  output  NUM_REQ  beat accepted when req_valid[i] & req_ready[i].
- buff_addr  output  ADDR_W  registered write address.
- buff_data  output  DATA_W  registered write data.
- buff_wr  output  1  write strobe/valid toward buffer.
- buff_ready  input  1  buffer accepts the current beat when buff_wr & buff_ready.
- grant_id  output  3  index of current/last granted requester.
- locked  output  1  burst in progress.

Behaviour:
- Reset (async, reset_n low):
  - buff_addr=0, buff_data=0, buff_wr=0, grant_id=0, locked=0.
  - rr_ptr=0; req_ready=0.
- slot_free = !buff_wr | buff_ready.
- Selection, combinational, same cycle:
  - If locked: candidate = grant_id only.
  - Else: first i with req_valid[i] & req_mask[i], searching from rr_ptr upward, wrapping modulo NUM_REQ.
- req_ready[sel] = ce & slot_free & candidate exists. All other bits are 0. At most one bit of req_ready is ever high.
- Accept (posedge, handshake on sel):
  - buff_addr/buff_data <= req_addr/req_data of sel; buff_wr <= 1; grant_id <= sel.
  - Latency: beat accepted in cycle N appears on buff_wr in cycle N+1.
- Drain: if buff_wr & buff_ready and no accept in the same cycle, buff_wr <= 0. This is independent of ce.
- Simultaneous drain and accept: the register reloads and buff_wr stays 1. This gives full throughput of 1 beat/cycle.
- Lock:
  - An accepted beat with req_last=0 sets locked=1.
  - An accepted beat with req_last=1 clears locked and sets rr_ptr <= (sel+1) mod NUM_REQ.
  - Unlocked single beats (last=1) also advance rr_ptr.
- While locked:
  - A req_mask drop on the owner takes effect only after its last beat.
  - Other requesters wait regardless of priority.
- ce=0: no acceptance, rr_ptr/locked frozen; the output register may still drain.
- buff_ready low with buff_wr=1: buff_addr/buff_data/buff_wr held stable; req_ready all 0.
- No valid unmasked requester: req_ready=0; rr_ptr unchanged.
- Requester dropping req_valid mid-burst: lock is kept, and the bus idles until it resumes. Its protocol obliges completion.
- Reset mid-burst: lock and the pending output beat are discarded (buff_wr=0 immediately).

Decomposition:
- gbuf_pkg: GBUF_ADDR_W=32, GBUF_DATA_W=32, GBUF_MAX_REQ=8, and a grant-id width constant of 3.
- Sub-module rr_priority_select: combinational rotate–find-first–unrotate. Inputs request vector and rr_ptr; outputs found and index.
- Top keeps the lock/ptr registers and the output stage.

Test Plan:
- Reset, then req_valid=4'b0101, last=1, buff_ready=1 held.
  - Grants alternate 0,2,0,2 on consecutive cycles.
  - buff_wr continuous from cycle 2.
  - buff_addr follows each granted requester one cycle later.
- Requester 1 bursts 4 beats (last on beat 4) while requester 3 is valid throughout.
  - buff_wr shows four beats of requester 1 back to back, then requester 3.
  - locked=1 for beats 1–3.
- buff_ready held low for 3 cycles with buff_wr=1, addr=0x100.
  - buff_addr stays 0x100 and req_ready=0 for those cycles.
  - Next beat appears one cycle after buff_ready rises.
- ce=0 for 2 cycles with pending requests and buff_wr=1, buff_ready=1.
  - Current beat drains (buff_wr→0); no req_ready asserted.
  - Arbitration resumes from the same rr_ptr when ce returns.
- req_mask[0]=0 with req_valid=4'b0011.
  - Only requester 1 granted.
  - Masking requester 1 mid-burst still completes its burst before idling.
- Assert reset_n low mid-burst (locked=1, buff_wr=1).
  - All outputs 0 immediately.
  - After release, the first grant goes to requester 0 if it is valid.

Source files
------------

// File: rtl/gbuf_pkg.sv
// Shared constants and helpers for the graphic-buffer write arbiter.
// Grant ids are GBUF_GID_W bits wide, so up to GBUF_MAX_REQ requesters fit.
package gbuf_pkg;

    localparam int GBUF_ADDR_W  = 32;
    localparam int GBUF_DATA_W  = 32;
    localparam int GBUF_MAX_REQ = 8;
    localparam int GBUF_GID_W   = 3;

    typedef logic [GBUF_GID_W-1:0] gid_t;

    // Returns (idx + 1) mod n. Assumes idx < n and n <= GBUF_MAX_REQ.
    function automatic gid_t wrap_inc(input gid_t idx, input int n);
        return (int'(idx) + 1 >= n) ? gid_t'(0) : idx + gid_t'(1);
    endfunction

endpackage

// File: rtl/gbuf_write_arbiter_if.sv
// Requester-side and buffer-side write bus of the arbiter.
// The arbiter connects through the slave modport; the driving environment uses master.
interface gbuf_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_mask;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         buff_addr;
    logic [DATA_W-1:0]         buff_data;
    logic                      buff_wr;
    logic                      buff_ready;

    modport slave (
        input  req_valid, req_last, req_addr, req_data, req_mask, buff_ready,
        output req_ready, buff_addr, buff_data, buff_wr
    );

    modport master (
        output req_valid, req_last, req_addr, req_data, req_mask, buff_ready,
        input  req_ready, buff_addr, buff_data, buff_wr
    );
endinterface

// File: rtl/rr_priority_select.sv
// Round-robin find-first: rotate the request vector so rr_ptr sits at bit 0,
// pick the lowest set bit, then map that position back to a requester index.
module rr_priority_select
    import gbuf_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  gid_t         ptr_i,
    output logic         found_o,
    output gid_t         idx_o
);

    logic [2*N-1:0] dbl_rot;
    logic [N-1:0]   rot;

    assign dbl_rot = {req_i, req_i} >> ptr_i;
    assign rot     = dbl_rot[N-1:0];

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found_o = 1'b1;
                idx_o   = gid_t'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/gbuf_write_arbiter.sv
// Round-robin, burst-locking arbiter for the single graphic-buffer write port,
// with a one-entry registered output stage under valid/ready backpressure.
module gbuf_write_arbiter
    import gbuf_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = GBUF_ADDR_W,
    parameter int DATA_W  = GBUF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ce,
    gbuf_write_arbiter_if.slave         bus,
    output gid_t                        grant_id,
    output logic                        locked
);

    logic [ADDR_W-1:0] buff_addr_q, buff_addr_d;
    logic [DATA_W-1:0] buff_data_q, buff_data_d;
    logic              buff_wr_q,   buff_wr_d;
    gid_t              grant_id_q,  grant_id_d;
    logic              locked_q,    locked_d;
    gid_t              rr_ptr_q,    rr_ptr_d;

    logic [NUM_REQ-1:0] cand_vec;
    logic [NUM_REQ-1:0] owner_onehot;
    logic               found;
    gid_t               sel;
    logic               slot_free;
    logic               accept;
    logic               sel_last;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // While a burst is open only the owner competes, and its mask is ignored
    // until the last beat so the burst cannot be stranded half-written.
    assign owner_onehot = NUM_REQ'(1) << grant_id_q;
    assign cand_vec     = locked_q ? (bus.req_valid & owner_onehot)
                                   : (bus.req_valid & bus.req_mask);

    rr_priority_select #(.N(NUM_REQ)) u_select (
        .req_i   (cand_vec),
        .ptr_i   (rr_ptr_q),
        .found_o (found),
        .idx_o   (sel)
    );

    assign slot_free = !buff_wr_q || bus.buff_ready;
    assign accept    = reset_n && ce && slot_free && found;
    assign sel_last  = 1'(bus.req_last >> sel);
    assign sel_addr  = ADDR_W'(bus.req_addr >> (int'(sel) * ADDR_W));
    assign sel_data  = DATA_W'(bus.req_data >> (int'(sel) * DATA_W));

    assign bus.req_ready = accept ? (NUM_REQ'(1) << sel) : '0;

    always_comb begin
        buff_addr_d = buff_addr_q;
        buff_data_d = buff_data_q;
        buff_wr_d   = buff_wr_q;
        grant_id_d  = grant_id_q;
        locked_d    = locked_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            buff_addr_d = sel_addr;
            buff_data_d = sel_data;
            buff_wr_d   = 1'b1;
            grant_id_d  = sel;
            locked_d    = !sel_last;
            if (sel_last) begin
                rr_ptr_d = wrap_inc(sel, NUM_REQ);
            end
        end else if (buff_wr_q && bus.buff_ready) begin
            buff_wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buff_addr_q <= '0;
            buff_data_q <= '0;
            buff_wr_q   <= 1'b0;
            grant_id_q  <= '0;
            locked_q    <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            buff_addr_q <= buff_addr_d;
            buff_data_q <= buff_data_d;
            buff_wr_q   <= buff_wr_d;
            grant_id_q  <= grant_id_d;
            locked_q    <= locked_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.buff_addr = buff_addr_q;
    assign bus.buff_data = buff_data_q;
    assign bus.buff_wr   = buff_wr_q;
    assign grant_id      = grant_id_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_gbuf_write_arbiter.sv
// Directed scenario bench for gbuf_write_arbiter with hand-computed expectations.
module tb_gbuf_write_arbiter;
    import gbuf_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk;
    logic reset_n;
    logic ce;
    gid_t grant_id;
    logic locked;
    int   errors;
    int   checks;

    gbuf_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    gbuf_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .bus      (bus.slave),
        .grant_id (grant_id),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr_of(input int i);
        return AW'(32'h1000 + i * 16);
    endfunction

    function automatic logic [DW-1:0] data_of(input int i);
        return DW'(32'hD000_0000 + i);
    endfunction

    task automatic set_beat(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    // Inputs change at posedge+1, combinational checks at posedge+4.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic default_inputs();
        ce             = 1'b1;
        bus.req_valid  = '0;
        bus.req_last   = '1;
        bus.req_mask   = '1;
        bus.buff_ready = 1'b1;
        for (int i = 0; i < N; i++) set_beat(i, addr_of(i), data_of(i));
    endtask

    task automatic do_reset();
        default_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_ready(input string name, input logic [N-1:0] exp);
        checks++;
        if (bus.req_ready !== exp) begin
            errors++;
            $display("FAIL %s: req_ready=%b expected %b", name, bus.req_ready, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input gid_t g, input logic lk);
        checks++;
        if (bus.buff_wr !== wr || bus.buff_addr !== a || bus.buff_data !== d ||
            grant_id !== g || locked !== lk) begin
            errors++;
            $display("FAIL %s: wr=%b addr=%h data=%h gid=%0d lock=%b expected wr=%b addr=%h data=%h gid=%0d lock=%b",
                     name, bus.buff_wr, bus.buff_addr, bus.buff_data, grant_id, locked,
                     wr, a, d, g, lk);
        end
    endtask

    task automatic test_reset();
        default_inputs();
        bus.req_valid = '1;
        reset_n = 1'b0;
        #2;
        chk_out("reset_outputs", 1'b0, '0, '0, 3'd0, 1'b0);
        chk_ready("reset_ready", 4'b0000);
        tick();
        reset_n = 1'b1;
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int exp_g [4] = '{0, 2, 0, 2};
        do_reset();
        bus.req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk_ready($sformatf("rr_ready_%0d", k), N'(1) << exp_g[k]);
            tick();
            chk_out($sformatf("rr_out_%0d", k), 1'b1, addr_of(exp_g[k]), data_of(exp_g[k]),
                    gid_t'(exp_g[k]), 1'b0);
        end
        bus.req_valid = '0;
        #3;
        chk_ready("rr_idle_ready", 4'b0000);
        tick();
        chk_out("rr_drain", 1'b0, addr_of(2), data_of(2), 3'd2, 1'b0);
    endtask

    task automatic test_burst_lock();
        do_reset();
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            set_beat(1, AW'(32'h200 + k), DW'(32'hB0 + k));
            bus.req_last = (k == 3) ? 4'b1111 : 4'b1101;
            #3;
            chk_ready($sformatf("burst_ready_%0d", k), 4'b0010);
            tick();
            chk_out($sformatf("burst_out_%0d", k), 1'b1, AW'(32'h200 + k), DW'(32'hB0 + k),
                    3'd1, k < 3);
        end
        bus.req_valid = 4'b1000;
        #3;
        chk_ready("burst_next_ready", 4'b1000);
        tick();
        chk_out("burst_next_out", 1'b1, addr_of(3), data_of(3), 3'd3, 1'b0);
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_beat(0, AW'(32'h100), DW'(32'hAA));
        bus.req_valid = 4'b0001;
        tick();
        chk_out("bp_first", 1'b1, AW'(32'h100), DW'(32'hAA), 3'd0, 1'b0);
        set_beat(0, AW'(32'h104), DW'(32'hBB));
        bus.buff_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk_ready($sformatf("bp_stall_ready_%0d", k), 4'b0000);
            tick();
            chk_out($sformatf("bp_hold_%0d", k), 1'b1, AW'(32'h100), DW'(32'hAA), 3'd0, 1'b0);
        end
        bus.buff_ready = 1'b1;
        #3;
        chk_ready("bp_resume_ready", 4'b0001);
        tick();
        chk_out("bp_next", 1'b1, AW'(32'h104), DW'(32'hBB), 3'd0, 1'b0);
        bus.req_valid = '0;
        tick();
        chk_out("bp_drain", 1'b0, AW'(32'h104), DW'(32'hBB), 3'd0, 1'b0);
    endtask

    task automatic test_clock_enable();
        do_reset();
        bus.req_valid = 4'b0101;
        tick();
        chk_out("ce_first", 1'b1, addr_of(0), data_of(0), 3'd0, 1'b0);
        ce = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #3;
            chk_ready($sformatf("ce_off_ready_%0d", k), 4'b0000);
            tick();
            chk_out($sformatf("ce_off_out_%0d", k), 1'b0, addr_of(0), data_of(0), 3'd0, 1'b0);
        end
        ce = 1'b1;
        #3;
        chk_ready("ce_resume_ready", 4'b0100);
        tick();
        chk_out("ce_resume_out", 1'b1, addr_of(2), data_of(2), 3'd2, 1'b0);
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_mask();
        do_reset();
        bus.req_valid = 4'b0011;
        bus.req_mask  = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            bus.req_last = (k == 2) ? 4'b1111 : 4'b1101;
            if (k == 1) bus.req_mask = 4'b1100;
            #3;
            chk_ready($sformatf("mask_ready_%0d", k), 4'b0010);
            tick();
            chk_out($sformatf("mask_out_%0d", k), 1'b1, addr_of(1), data_of(1), 3'd1, k < 2);
        end
        #3;
        chk_ready("mask_idle_ready", 4'b0000);
        tick();
        chk_out("mask_idle_out", 1'b0, addr_of(1), data_of(1), 3'd1, 1'b0);
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req_valid = 4'b0010;
        bus.req_last  = 4'b0000;
        tick();
        chk_out("rmb_locked", 1'b1, addr_of(1), data_of(1), 3'd1, 1'b1);
        bus.req_valid  = 4'b0011;
        bus.buff_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk_out("rmb_cleared", 1'b0, '0, '0, 3'd0, 1'b0);
        chk_ready("rmb_ready", 4'b0000);
        tick();
        reset_n = 1'b1;
        bus.buff_ready = 1'b1;
        bus.req_last = '1;
        #3;
        chk_ready("rmb_after_ready", 4'b0001);
        tick();
        chk_out("rmb_after_out", 1'b1, addr_of(0), data_of(0), 3'd0, 1'b0);
        bus.req_valid = '0;
        tick();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        default_inputs();
        tick();
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_backpressure();
        test_clock_enable();
        test_mask();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
